// File: rtl/inst_mem_loader.sv
// inst_mem_loader: boot stage that streams a length-prefixed, little-endian image into instruction
// memory and then raises start. Define INST_LOADER_CHECKSUM_EN to require a trailing XOR check byte.
module inst_mem_loader #(
    parameter int DEPTH = 256,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_req,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        start,
    output logic        busy,
    output logic        err
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // DONE covers the cycle in which the final write is on the port, so start and busy swap together.
    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
`ifdef INST_LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE,
        RUN,
        ERR
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   length_q, length_d;
    logic [IDX_W-1:0]   word_idx_q, word_idx_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic [23:0]        asm_q, asm_d;
    logic               wr_en_q, wr_en_d;
    logic [31:0]        wr_addr_q, wr_addr_d;
    logic [31:0]        wr_data_q, wr_data_d;
    logic               start_q, start_d;
    logic               err_q, err_d;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif

    logic               xfer;
    logic [CNT_W-1:0]   header_len;
    logic               last_word;

    always_comb begin
        byte_ready = 1'b0;
        busy       = 1'b0;
        case (state_q)
            LEN0, LEN1, DATA: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
`ifdef INST_LOADER_CHECKSUM_EN
            CHK: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
`endif
            DONE:    busy = 1'b1;
            default: ;
        endcase
    end

    assign xfer = byte_valid & byte_ready;

    always_comb begin
        state_d    = state_q;
        length_d   = length_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        start_d    = start_q;
        err_d      = err_q;
`ifdef INST_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        header_len = CNT_W'({byte_data, length_q[7:0]});
        last_word  = (32'(word_idx_q) == 32'(length_q) - 32'd1);

        case (state_q)
            IDLE: begin
                if (load_req) state_d = LEN0;
            end
            LEN0: begin
                if (xfer) begin
                    length_d[7:0] = byte_data;
                    state_d       = LEN1;
                end
            end
            LEN1: begin
                if (xfer) begin
                    length_d = header_len;
                    if (header_len == '0 || 32'(header_len) > 32'(DEPTH)) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d    = DATA;
                        word_idx_d = '0;
                        byte_cnt_d = '0;
`ifdef INST_LOADER_CHECKSUM_EN
                        csum_d     = '0;
`endif
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ byte_data;
`endif
                    case (byte_cnt_q)
                        2'd0:    asm_d[7:0]   = byte_data;
                        2'd1:    asm_d[15:8]  = byte_data;
                        2'd2:    asm_d[23:16] = byte_data;
                        default: begin
                            wr_en_d    = 1'b1;
                            wr_addr_d  = {{(30-IDX_W){1'b0}}, word_idx_q, 2'b00};
                            wr_data_d  = {byte_data, asm_q};
                            word_idx_d = word_idx_q + 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
                            if (last_word) state_d = CHK;
`else
                            if (last_word) state_d = DONE;
`endif
                        end
                    endcase
                end
            end
`ifdef INST_LOADER_CHECKSUM_EN
            CHK: begin
                if (xfer) begin
                    if (byte_data == csum_q) begin
                        state_d = RUN;
                        start_d = 1'b1;
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
            end
`endif
            DONE: begin
                state_d = RUN;
                start_d = 1'b1;
            end
            RUN, ERR: begin
                if (load_req) begin
                    state_d = LEN0;
                    start_d = 1'b0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            length_q   <= '0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            start_q    <= 1'b0;
            err_q      <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            length_q   <= length_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            start_q    <= start_d;
            err_q      <= err_d;
`ifdef INST_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign start   = start_q;
    assign err     = err_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: drives byte streams into inst_mem_loader and compares every cycle against a
// stream-position model of the load; INST_LOADER_CHECKSUM_EN adds the checksum byte to each stream.
module tb_inst_mem_loader;
    localparam int DEPTH = 256;
`ifdef INST_LOADER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        clk;
    logic        rst;
    logic        load_req;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        start;
    logic        busy;
    logic        err;

    inst_mem_loader #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_req   (load_req),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .busy       (busy),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int assert_count = 0;
    int fail_count   = 0;
    int cyc          = 0;

    // Model state: position in the current byte stream rather than any FSM encoding.
    bit          model_live = 1'b0;
    bit          m_loading, m_finish;
    int          m_pos, m_len;
    logic [31:0] m_word;
    logic [7:0]  m_xor;
    logic        e_wr_en, e_start, e_err;
    logic [31:0] e_wr_addr, e_wr_data;

    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    int          last_wr_cyc, start_rise_cyc;
    logic        prev_start;
    logic [7:0]  stim[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic bit modelAccepting();
        return m_loading && !m_finish && (m_pos < 2 || m_pos < 2 + 4 * m_len + CS);
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            model_live = 1'b1;
            m_loading  = 1'b0;
            m_finish   = 1'b0;
            m_pos      = 0;
            m_len      = 0;
            m_word     = '0;
            m_xor      = '0;
            e_wr_en    = 1'b0;
            e_wr_addr  = '0;
            e_wr_data  = '0;
            e_start    = 1'b0;
            e_err      = 1'b0;
        end else if (model_live) begin
            e_wr_en = 1'b0;
            if (m_finish) begin
                m_finish  = 1'b0;
                m_loading = 1'b0;
                e_start   = 1'b1;
            end else if (m_loading) begin
                if (byte_valid && modelAccepting()) begin
                    m_pos++;
                    if (m_pos == 1) begin
                        m_len = int'(byte_data);
                    end else if (m_pos == 2) begin
                        m_len = m_len + int'(byte_data) * 256;
                        if (m_len == 0 || m_len > DEPTH) begin
                            m_loading = 1'b0;
                            e_err     = 1'b1;
                        end
                    end else if (m_pos <= 2 + 4 * m_len) begin
                        int d;
                        d      = m_pos - 3;
                        m_xor  = m_xor ^ byte_data;
                        m_word = {byte_data, m_word[31:8]};
                        if (d % 4 == 3) begin
                            e_wr_en   = 1'b1;
                            e_wr_addr = 32'((d / 4) * 4);
                            e_wr_data = m_word;
                            if (d / 4 == m_len - 1 && CS == 0) m_finish = 1'b1;
                        end
                    end else begin
                        m_loading = 1'b0;
                        if (byte_data == m_xor) e_start = 1'b1;
                        else e_err = 1'b1;
                    end
                end
            end else if (load_req) begin
                m_loading = 1'b1;
                m_pos     = 0;
                m_xor     = '0;
                e_start   = 1'b0;
                e_err     = 1'b0;
            end
        end
    end

    // Single compare process: every output against the model, every cycle after the first reset edge.
    always @(negedge clk) begin
        if (model_live) begin
            checkOutput("wr_en", 32'(wr_en), 32'(e_wr_en));
            checkOutput("wr_addr", wr_addr, e_wr_addr);
            checkOutput("wr_data", wr_data, e_wr_data);
            checkOutput("start", 32'(start), 32'(e_start));
            checkOutput("err", 32'(err), 32'(e_err));
            checkOutput("busy", 32'(busy), 32'(m_loading));
            checkOutput("byte_ready", 32'(byte_ready), 32'(modelAccepting()));
            if (wr_en === 1'b1) begin
                obs_addr.push_back(wr_addr);
                obs_data.push_back(wr_data);
                last_wr_cyc = cyc;
            end
            if (start === 1'b1 && prev_start !== 1'b1) start_rise_cyc = cyc;
            prev_start = start;
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clearLog();
        obs_addr.delete();
        obs_data.delete();
    endtask

    task automatic pulseLoad();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic appendCsum();
`ifdef INST_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = '0;
        for (int i = 2; i < stim.size(); i++) x = x ^ stim[i];
        stim.push_back(x);
`endif
    endtask

    task automatic sendByte(input logic [7:0] b, output bit ok);
        int wait_cnt;
        wait_cnt   = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && wait_cnt < 40) begin
            @(negedge clk);
            wait_cnt++;
        end
        ok = (byte_ready === 1'b1);
        if (!ok) checkOutput("byte_ready timeout", 32'(byte_ready), 32'd1);
        else @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic applyStimulus(input int fixed_gap, input int rand_gap, input int noisy_idx);
        bit ok;
        for (int i = 0; i < stim.size(); i++) begin
            if (i == noisy_idx) load_req = 1'b1;
            sendByte(stim[i], ok);
            load_req = 1'b0;
            if (!ok) break;
            waitCycles(fixed_gap + int'($urandom_range(0, rand_gap)));
        end
    endtask

    task automatic checkWrite(input string name, input int idx, input logic [31:0] addr, input logic [31:0] data);
        checkOutput({name, " addr"}, (idx < obs_addr.size()) ? obs_addr[idx] : 32'hFFFF_FFFF, addr);
        checkOutput({name, " data"}, (idx < obs_data.size()) ? obs_data[idx] : 32'hFFFF_FFFF, data);
    endtask

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int len;
        rst        = 1'b1;
        load_req   = 1'b0;
        byte_valid = 1'b0;
        byte_data  = '0;
        prev_start = 1'b0;
        waitCycles(2);
        rst = 1'b0;
        checkOutput("reset start", 32'(start), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset byte_ready", 32'(byte_ready), 32'd0);
        checkOutput("reset wr_en", 32'(wr_en), 32'd0);

        $display("[TB] two-word load");
        clearLog();
        pulseLoad();
        stim = {8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
        appendCsum();
        applyStimulus(0, 0, -1);
        waitCycles(3);
        checkOutput("twoWord count", 32'(obs_addr.size()), 32'd2);
        checkWrite("twoWord w0", 0, 32'h0, 32'h0050_0513);
        checkWrite("twoWord w1", 1, 32'h4, 32'h00A0_0593);
        checkOutput("twoWord start", 32'(start), 32'd1);
        checkOutput("twoWord start delay", 32'(start_rise_cyc - last_wr_cyc), 32'd1);

        $display("[TB] length errors");
        clearLog();
        pulseLoad();
        stim = {8'h00, 8'h00};
        applyStimulus(0, 0, -1);
        waitCycles(2);
        checkOutput("len0 err", 32'(err), 32'd1);
        checkOutput("len0 start", 32'(start), 32'd0);
        checkOutput("len0 writes", 32'(obs_addr.size()), 32'd0);
        pulseLoad();
        stim = {8'h01, 8'h01};
        applyStimulus(0, 0, -1);
        waitCycles(2);
        checkOutput("len257 err", 32'(err), 32'd1);
        checkOutput("len257 writes", 32'(obs_addr.size()), 32'd0);

        $display("[TB] full-depth load");
        clearLog();
        pulseLoad();
        stim = {8'h00, 8'h01};
        for (int k = 0; k < 4 * DEPTH; k++) stim.push_back(8'($urandom));
        appendCsum();
        applyStimulus(0, 0, -1);
        waitCycles(3);
        checkOutput("full count", 32'(obs_addr.size()), 32'd256);
        checkOutput("full last addr", (obs_addr.size() > 0) ? obs_addr[$] : 32'hFFFF_FFFF, 32'h3FC);
        checkOutput("full start", 32'(start), 32'd1);

        $display("[TB] backpressure gaps");
        clearLog();
        pulseLoad();
        stim = {8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
        appendCsum();
        applyStimulus(3, 0, -1);
        waitCycles(3);
        checkOutput("gaps count", 32'(obs_addr.size()), 32'd2);
        checkWrite("gaps w0", 0, 32'h0, 32'h0050_0513);
        checkWrite("gaps w1", 1, 32'h4, 32'h00A0_0593);

        $display("[TB] reload");
        byte_valid = 1'b1;
        byte_data  = 8'h5A;
        waitCycles(3);
        byte_valid = 1'b0;
        clearLog();
        pulseLoad();
        checkOutput("reload start low", 32'(start), 32'd0);
        checkOutput("reload busy", 32'(busy), 32'd1);
        stim = {8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        appendCsum();
        applyStimulus(0, 0, -1);
        waitCycles(3);
        checkOutput("reload count", 32'(obs_addr.size()), 32'd1);
        checkWrite("reload w0", 0, 32'h0, 32'hDEAD_BEEF);
        checkOutput("reload start", 32'(start), 32'd1);

        $display("[TB] random loads");
        repeat (6) begin
            clearLog();
            pulseLoad();
            len = int'($urandom_range(1, 8));
            stim.delete();
            stim.push_back(len[7:0]);
            stim.push_back(len[15:8]);
            for (int k = 0; k < 4 * len; k++) stim.push_back(8'($urandom));
            appendCsum();
            applyStimulus(0, 2, 3);
            waitCycles(3);
            checkOutput("random count", 32'(obs_addr.size()), 32'(len));
            checkOutput("random start", 32'(start), 32'd1);
        end

`ifdef INST_LOADER_CHECKSUM_EN
        $display("[TB] checksum");
        clearLog();
        pulseLoad();
        stim = {8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        applyStimulus(0, 0, -1);
        waitCycles(2);
        checkWrite("csum good w0", 0, 32'h0, 32'h4433_2211);
        checkOutput("csum good start", 32'(start), 32'd1);
        checkOutput("csum good err", 32'(err), 32'd0);
        pulseLoad();
        stim = {8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        applyStimulus(0, 0, -1);
        waitCycles(2);
        checkOutput("csum bad err", 32'(err), 32'd1);
        checkOutput("csum bad start", 32'(start), 32'd0);
`endif

        $display("[TB] reset mid-load");
        clearLog();
        pulseLoad();
        stim = {8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        applyStimulus(0, 0, -1);
        rst = 1'b1;
        waitCycles(2);
        rst = 1'b0;
        checkOutput("midReset pulses", 32'(obs_addr.size()), 32'd1);
        checkOutput("midReset start", 32'(start), 32'd0);
        checkOutput("midReset err", 32'(err), 32'd0);
        checkOutput("midReset busy", 32'(busy), 32'd0);
        checkOutput("midReset byte_ready", 32'(byte_ready), 32'd0);
        checkOutput("midReset wr_data", wr_data, 32'd0);
        waitCycles(3);
        checkOutput("midReset no late pulse", 32'(obs_addr.size()), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end
endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Upstream boot stage for the single-cycle RISC-V core.
- Receives a little-endian byte stream (word count header + instruction words) over a valid/ready handshake, writes each assembled 32-bit word into instruction memory through a write port, then drives the core's `start` high.
- While loading, `start` is held low, which keeps the core in reset.

Parameters:
- DEPTH, 256, instruction memory size in 32-bit words; maximum accepted word count.
- CNT_W, 16, width of the word-count header; always 2 bytes at the default value.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- load_req  in  1  single-cycle request to begin or restart a load.
- byte_valid  in  1  byte_data is valid this cycle.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader can accept a byte this cycle.
- wr_en  out  1  instruction memory write strobe, one cycle per word.
- wr_addr  out  32  byte address of the word being written (word_index*4).
- wr_data  out  32  assembled instruction word.
- start  out  1  run enable to the core; 0 holds the core in reset.
- busy  out  1  high in LEN0, LEN1, DATA and CHK.
- err  out  1  load failed.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high. While `rst`=1 at a clock edge:
  - state goes to IDLE;
  - every output goes to 0;
  - the word counter, byte counter, length register and assembly register are cleared.
- Transfer rule: a byte transfers on a clock edge where byte_valid & byte_ready.
- byte_ready is combinational from state: 1 in LEN0, LEN1, DATA and CHK; 0 elsewhere.
- FSM:
  - IDLE: load_req -> LEN0. All other inputs are ignored.
  - LEN0: on transfer, length[7:0] = byte -> LEN1.
  - LEN1: on transfer, length[15:8] = byte, then the length is checked:
    - length==0 or length>DEPTH -> ERR;
    - otherwise -> DATA, with word_idx=0 and byte_cnt=0.
  - DATA: each transfer places the byte at lane byte_cnt (lane 0 = bits 7:0) and increments byte_cnt mod 4.
    - On the transfer with byte_cnt==3, the next cycle has wr_en=1, wr_addr=word_idx*4 and wr_data=the full word, for exactly one cycle. word_idx then increments.
    - When the last word (word_idx==length-1) is written, go to RUN. With CHECKSUM_EN, go to CHK instead.
  - RUN: start=1 from the cycle after the final wr_en pulse. Held until rst or load_req.
  - ERR: err=1, start=0. Held until rst or load_req.
- load_req handling:
  - In RUN or ERR: next cycle start=0 and err=0, state LEN0. This is a reload that resets the core.
  - In LEN0, LEN1, DATA or CHK: ignored.
- wr_en, wr_addr and wr_data are registered. wr_addr/wr_data hold their last values when wr_en=0.
- Bytes offered while byte_ready=0 are neither consumed nor buffered.
- byte_valid may drop mid-word. Partial assembly is held indefinitely with no timeout.
- Reset mid-load: the load is abandoned, no further wr_en pulses occur, and the block returns to IDLE.
- Memory contents already written are not cleared.
- wr_addr never exceeds (DEPTH-1)*4.

Optional Feature:
- Macro: INST_LOADER_CHECKSUM_EN.
- With the macro defined:
  - After the last data byte, state CHK accepts one extra byte.
  - If that byte equals the XOR of all data bytes (header excluded), go to RUN; otherwise go to ERR.
  - The final word is still written before the check.
  - start rises the cycle after the checksum byte transfers.
- Without the macro: no CHK state, and RUN follows the last write as described in Behaviour.

Test Plan:
- Two-word load:
  - Stimulus: rst 2 cycles, load_req, then bytes 02 00 | 13 05 50 00 | 93 05 A0 00, continuous valid.
  - Expected: wr_en pulses at addr 0x0 with data 0x00500513, then addr 0x4 with 0x00A00593. start=1 one cycle after the second pulse. busy falls with start's rise.
- Length errors:
  - Header 00 00 -> err=1, no wr_en, start stays 0.
  - Header 01 01 (257 > DEPTH=256) -> err=1.
- Backpressure gaps:
  - Stimulus: same stream as the two-word load, with byte_valid deasserted 3 cycles between every byte.
  - Expected: identical writes and data, only later in time; no extra wr_en pulses.
- Reload:
  - Stimulus: after the two-word load reaches RUN, pulse load_req, then send 01 00 EF BE AD DE.
  - Expected: start=0 the cycle after load_req; one write of 0xDEADBEEF at addr 0x0; start=1 again.
- Reset mid-load:
  - Stimulus: rst asserted after 6 data bytes of a 4-word load.
  - Expected: exactly 1 wr_en pulse observed; then IDLE with outputs 0 and byte_ready=0.
- INST_LOADER_CHECKSUM_EN:
  - 01 00 11 22 33 44 44 -> RUN, start=1 (XOR of 11,22,33,44 = 0x44).
  - 01 00 11 22 33 44 00 -> err=1, start=0.
